// File: rtl/ic_router_nport.sv
`default_nettype none
// ============================================================================
// Module  : ic_router_nport
// Brief   : Single-master to N-slave req/gnt/recv/ack router with in-order
//           route FIFO and internal decode-error responder.
// Revision: 1.0
// ============================================================================
module ic_router_nport #(
    parameter int                 NSLV            = 3,
    parameter int                 MAX_OUTSTANDING = 2,
    parameter logic [NSLV*32-1:0] MAP_MATCH       = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NSLV*32-1:0] MAP_MASK        = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_C000}
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 m_req,
    input  logic                 m_wen,
    input  logic [3:0]           m_strb,
    input  logic [31:0]          m_wdata,
    input  logic [31:0]          m_addr,
    output logic                 m_gnt,
    output logic                 m_recv,
    output logic                 m_error,
    output logic [31:0]          m_rdata,
    input  logic                 m_ack,
    output logic [NSLV-1:0]      s_req,
    output logic [NSLV-1:0]      s_wen,
    output logic [4*NSLV-1:0]    s_strb,
    output logic [32*NSLV-1:0]   s_wdata,
    output logic [32*NSLV-1:0]   s_addr,
    input  logic [NSLV-1:0]      s_gnt,
    input  logic [NSLV-1:0]      s_recv,
    input  logic [NSLV-1:0]      s_error,
    input  logic [32*NSLV-1:0]   s_rdata,
    output logic [NSLV-1:0]      s_ack
);

    localparam int c_DW = $clog2(NSLV + 1);
    localparam int c_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [c_DW-1:0] c_ERR      = c_DW'(NSLV);
    localparam logic [c_CW-1:0] c_MAX      = c_CW'(MAX_OUTSTANDING);
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(MAX_OUTSTANDING - 1);

    logic [c_DW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_DW-1:0] r_last_dst;

    logic [c_DW-1:0] w_dst;
    logic [c_DW-1:0] w_head;
    logic            w_ok;
    logic            w_sel_gnt;
    logic            w_push;
    logic            w_pop;

    assign s_wen   = {NSLV{m_wen}};
    assign s_strb  = {NSLV{m_strb}};
    assign s_wdata = {NSLV{m_wdata}};
    assign s_addr  = {NSLV{m_addr}};

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_dst = c_ERR;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_addr & MAP_MASK[i*32 +: 32]) == MAP_MATCH[i*32 +: 32]) begin
                w_dst = c_DW'(i);
            end
        end
    end

    // Issue only from registered state; a destination switch waits for an empty FIFO.
    assign w_ok = g_resetn && (r_count < c_MAX) &&
                  ((r_count == '0) || (w_dst == r_last_dst));

    always_comb begin
        s_req     = '0;
        w_sel_gnt = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (w_dst == c_DW'(i)) begin
                s_req[i]  = m_req && w_ok;
                w_sel_gnt = s_gnt[i];
            end
        end
        m_gnt = w_ok && m_req && ((w_dst == c_ERR) || w_sel_gnt);
    end

    assign w_head = r_fifo[r_rd_ptr];

    always_comb begin
        m_recv  = 1'b0;
        m_error = 1'b0;
        m_rdata = '0;
        s_ack   = '0;
        if (g_resetn && (r_count != '0)) begin
            if (w_head == c_ERR) begin
                m_recv  = 1'b1;
                m_error = 1'b1;
            end else begin
                for (int i = 0; i < NSLV; i++) begin
                    if (w_head == c_DW'(i)) begin
                        m_recv   = s_recv[i];
                        m_error  = s_error[i];
                        m_rdata  = s_rdata[i*32 +: 32];
                        s_ack[i] = m_ack;
                    end
                end
            end
        end
    end

    assign w_push = m_req && m_gnt;
    assign w_pop  = m_recv && m_ack;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_last_dst <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_dst;
                r_last_dst       <= w_dst;
                r_wr_ptr         <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ic_router_nport.md
# ic_router_nport

Parametrised single-master to N-slave memory interconnect router using the SoC req/gnt/recv/ack handshake. It decodes each master request against per-slave match/mask windows and forwards it to the selected slave. It tracks up to `MAX_OUTSTANDING` granted requests in a route FIFO and returns responses in order. Unmapped addresses are answered by an internal decode-error responder. One instance sits on each CPU port (imem, dmem) between the core and the ROM/RAM/AXI-bridge slaves.

## Interface
- `NSLV`, 3: number of slave ports (1..7).
- `MAX_OUTSTANDING`, 2: route FIFO depth, power of two, ≥1.
- `MAP_MATCH`, {32'h4000_0000, 32'h2000_0000, 32'h1000_0000}: NSLV×32 packed; slice i is slave i's base.
- `MAP_MASK`, {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_C000}: NSLV×32 packed; slice i is slave i's mask.

Ports:
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, synchronous, active-low. Clock is `g_clk`.
- `m_req` in 1, `m_wen` in 1, `m_strb` in 4, `m_wdata` in 32, `m_addr` in 32: master request.
- `m_gnt` out 1: request accepted.
- `m_recv` out 1, `m_error` out 1, `m_rdata` out 32: response.
- `m_ack` in 1: master accepts response.
- `s_req` out NSLV: per-slave request.
- `s_wen` out NSLV, `s_strb` out 4×NSLV, `s_wdata` out 32×NSLV, `s_addr` out 32×NSLV: broadcast copies of the master fields.
- `s_gnt` in NSLV, `s_recv` in NSLV, `s_error` in NSLV, `s_rdata` in 32×NSLV: slave replies.
- `s_ack` out NSLV: per-slave response accept.

## Operation
- Decode:
  - `hit[i] = (m_addr & MASK_i) == MATCH_i`.
  - On multiple hits, the lowest index wins.
  - No hit selects destination ERR (id NSLV).
  - Destination id width is clog2(NSLV+1).
- Route FIFO: holds destination ids. State is `count`, `rd_ptr`, `wr_ptr` and `last_dst` (id of the most recent push).
- Issue permission (registered state only): `ok = count < MAX_OUTSTANDING && (count == 0 || dst == last_dst)`.
  - All outstanding requests therefore target one destination, so responses cannot reorder across slaves.
- Request forwarding:
  - `s_req[i] = m_req && ok && dst == i`.
  - `m_gnt = ok && m_req && (dst == ERR ? 1 : s_gnt[dst])`.
- Push: when `m_req && m_gnt`, write `dst` at `wr_ptr` and set `last_dst = dst`.
- Response selection, with `h` = FIFO head id and `count > 0`:
  - Slave head: `m_recv = s_recv[h]`, `m_error = s_error[h]`, `m_rdata = s_rdata[h]`, `s_ack[h] = m_ack`.
  - ERR head: `m_recv = 1`, `m_error = 1`, `m_rdata = 0`; no `s_ack` is asserted.
  - All other `s_ack` bits are 0.
  - When `count == 0`: `m_recv = 0`, `m_error = 0`, `m_rdata = 0`.
- Pop: when `m_recv && m_ack`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. Pointers wrap modulo `MAX_OUTSTANDING`.
- `s_recv`/`s_error` from a slave that is not at the head are ignored and never acked.
- Reset:
  - State: `count = 0`, pointers 0, `last_dst = 0`.
  - While `g_resetn` is low: `m_gnt = 0`, `s_req = 0`, `s_ack = 0`, `m_recv = 0`, `m_error = 0`, `m_rdata = 0`.
- Reset mid-operation discards all outstanding entries. Slaves must be reset in the same cycle.

## Timing
- Request path is combinational: `m_req` → `s_req` → `s_gnt` → `m_gnt` in the same cycle. No registers in the forward path.
- Response path is combinational from `s_recv`/`s_rdata` to `m_*`.
- Earliest response is the cycle after grant; a FIFO entry becomes visible at the head the next cycle.
- ERR response: `m_recv = 1` the cycle after grant, held until `m_ack`.
- Throughput is one grant per cycle while `ok` holds.
- Destination switch:
  - A request to a new destination stalls (`m_gnt = 0`) until `count` returns to 0 on a clock edge.
  - The pop-to-empty cycle does not itself permit a switch. The switched request is granted at the earliest one cycle after the final pop.
- FIFO full: `m_gnt = 0` even if a pop occurs in the same cycle.

## Test plan
- **Single read to RAM:**
  - Stimulus: `m_addr = 0x2000_0010`, `s_gnt[1] = 1`; next cycle `s_recv[1] = 1`, `s_rdata[1] = 0xDEAD_BEEF`, `m_ack = 1`.
  - Required: `s_req = 3'b010`; `m_rdata = 0xDEAD_BEEF`; `s_ack[1] = 1`; `count` returns to 0.
- **Decode error:**
  - Stimulus: `m_addr = 0x3000_0000`.
  - Required: `m_gnt = 1` immediately with `s_req = 0`; next cycle `m_recv = 1`, `m_error = 1`, `m_rdata = 0`, held until `m_ack`.
- **Pipelining:**
  - Stimulus: two back-to-back ROM reads (0x1000_0000, 0x1000_0004) with `MAX_OUTSTANDING = 2`; a third ROM read before any response.
  - Required: first two granted in consecutive cycles; third stalled (`m_gnt = 0`) until the first response pops.
- **Cross-slave ordering:**
  - Stimulus: ROM read outstanding, then a RAM read request.
  - Required: `s_req[1] = 0` until the ROM response is acked; RAM granted the cycle after the pop; `rdata` returned in issue order.
- **Stray response:**
  - Stimulus: `s_recv[2] = 1` while the head is ROM.
  - Required: `m_recv` tracks `s_recv[0]` only; `s_ack[2] = 0`.
- **Reset mid-operation:**
  - Stimulus: two requests outstanding, assert `g_resetn = 0` for one cycle.
  - Required: all outputs 0 during reset; after release `count = 0` and a fresh RAM request is granted with no stale response delivered.
